// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM states and per-frame mode.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period counter with tick and leading/trailing edge strobes.
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic shift,
  output logic tick,
  output logic leading_edge,
  output logic trailing_edge
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  assign tick          = en && (cnt_q == LAST);
  assign leading_edge  = tick && shift && !phase_q;
  assign trailing_edge = tick && shift && phase_q;

  // Disabled outside a frame, so the count restarts at zero on SETUP entry.
  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    if (en) begin
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      phase_d = (tick && shift) ? ~phase_q : phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master, one DATA_W frame per request, CPOL/CPHA per frame.
// Define SPI_MASTER_LSB_FIRST_EN to add the lsb_first input.
module spi_master
  import spi_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NUM_CS  = 1,
  parameter  int CLK_DIV = 2,
  localparam int CS_W    = cs_width(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
`ifdef SPI_MASTER_LSB_FIRST_EN
  ,
  input  logic              lsb_first
`endif
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              lsb_in, lsb_cur;
  logic              tick, lead, trail;
  logic              drive_ev, sample_ev;

`ifdef SPI_MASTER_LSB_FIRST_EN
  logic lsb_q, lsb_d;
  assign lsb_in  = lsb_first;
  assign lsb_cur = lsb_q;
`else
  assign lsb_in  = 1'b0;
  assign lsb_cur = 1'b0;
`endif

  function automatic logic first_bit(
    input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] next_sh(
    input logic [DATA_W-1:0] d, input logic lsb);
    return lsb ? (d >> 1) : (d << 1);
  endfunction

  function automatic logic [NUM_CS-1:0] cs_dec(
    input logic [CS_W-1:0] s);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (CS_W'(i) == s) m[i] = 1'b0;
    return m;
  endfunction

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk          (clk),
    .rst          (rst),
    .en           (state_q inside {SETUP, SHIFT, HOLD}),
    .shift        (state_q == SHIFT),
    .tick         (tick),
    .leading_edge (lead),
    .trailing_edge(trail)
  );

  // cpha=0 pre-drives bit 0 at accept, so the last trailing edge drives nothing.
  assign drive_ev  = mode_q.cpha ? lead : (trail && bit_q != LAST_BIT);
  assign sample_ev = mode_q.cpha ? trail : lead;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    bit_d      = bit_q;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_d      = lsb_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d     = SETUP;
          mode_d.cpol = cpol;
          mode_d.cpha = cpha;
          sclk_d      = cpol;
          cs_n_d      = cs_dec(cs_sel);
          bit_d       = '0;
          rx_sh_d     = '0;
          tx_sh_d     = tx_data;
`ifdef SPI_MASTER_LSB_FIRST_EN
          lsb_d       = lsb_first;
`endif
          if (!cpha) begin
            mosi_d  = first_bit(tx_data, lsb_in);
            tx_sh_d = next_sh(tx_data, lsb_in);
          end
        end
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) sclk_d = ~sclk_q;
        if (drive_ev) begin
          mosi_d  = first_bit(tx_sh_q, lsb_cur);
          tx_sh_d = next_sh(tx_sh_q, lsb_cur);
        end
        if (sample_ev)
          rx_sh_d = lsb_cur ? {miso, rx_sh_q[DATA_W-1:1]}
                            : {rx_sh_q[DATA_W-2:0], miso};
        if (trail) begin
          if (bit_q == LAST_BIT) state_d = HOLD;
          else bit_d = bit_q + 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          state_d    = DONE;
          cs_n_d     = '1;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      bit_q      <= '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
      lsb_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      bit_q      <= bit_d;
`ifdef SPI_MASTER_LSB_FIRST_EN
      lsb_q      <= lsb_d;
`endif
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule
